seg7_display_scheduler: RTL
===========================

// Module: seg7_display_scheduler
// PURPOSE
// - Arbiter/sequencer in front of the 4-digit 7-seg driver; time-shares the display among three sources.
// - Ch0: live background (score), shown whenever no message is active.
// - Ch1: timed message (combo). Ch2: timed, blinking alert (miss); Ch2 has highest priority.
// - Drives the driver's enables and digit3..digit0 inputs; all outputs registered.
// PARAMETERS
// - HOLD_CYCLES  50_000_000  cycles a ch1/ch2 message stays on display (sim: 8)
// - BLINK_CYCLES 12_500_000  half-period of the ch2 blink (sim: 2)
// PORTS
// - clk        in   1   system clock, 100 MHz
// - clear      in   1   synchronous, active-low reset
// - bg_digits  in   16  ch0 value {d3,d2,d1,d0}, sampled live every cycle
// - bg_en      in   4   ch0 digit enables
// - req1       in   1   ch1 one-cycle request; msg1/en1 captured on same edge
// - msg1       in   16  ch1 digits
// - en1        in   4   ch1 digit enables
// - req2       in   1   ch2 one-cycle request; msg2/en2 captured on same edge
// - msg2       in   16  ch2 digits
// - en2        in   4   ch2 digit enables
// - digit3..0  out  4 ea  to display driver
// - enables    out  4   to display driver
// - active_ch  out  2   0/1/2 = channel currently shown
// - done1      out  1   one-cycle pulse when a ch1 message completes its full hold
// - done2      out  1   one-cycle pulse when a ch2 message completes its full hold
// BEHAVIOUR
// - Reset (clear==0 at an edge): state IDLE; digits 0; enables 0000; active_ch 0; done* 0;
//   pending1 0; hold counter 0; blink_phase 1. Requests on reset edges are discarded.
// - States: IDLE (show ch0), SHOW1, SHOW2. Outputs reflect the state one edge after the event.
//   Example: req at edge t is visible after edge t+1.
// - IDLE: outputs follow bg_digits/bg_en with one cycle of latency.
// - Entering SHOW1/SHOW2: the hold counter loads HOLD_CYCLES-1 and decrements each cycle.
// - Exit on the cycle the counter reads 0, so a message is shown exactly HOLD_CYCLES cycles.
//   On exit, pulse done*; next state is SHOW1 if pending1, else IDLE.
// - SHOW2 blink: enables = blink_phase ? en2 : 0000. blink_phase is forced to 1 on SHOW2 entry
//   and toggles every BLINK_CYCLES. SHOW1 output is steady.
// - req2 in any state: latch msg2/en2, go to SHOW2, reload the hold counter.
//   If this preempts SHOW1, the ch1 message is kept and pending1 is set.
//   Re-request in SHOW2 restarts the message with new data.
// - req1 in IDLE: latch, go to SHOW1. req1 in SHOW1: overwrite data, restart the hold.
//   req1 in SHOW2: latch, set pending1 (a newer req1 overwrites the pending data).
// - Pending ch1 restarts with a full HOLD_CYCLES after ch2 ends; it gets no done1 while preempted.
// - req1 and req2 on the same edge: ch2 is shown, ch1 is pending.
// - req2 on the exit cycle of SHOW2: treated as a restart; no done2.
// - req1 on the exit cycle of SHOW1: restart; no done1.
// - Hold and blink counters sized with $clog2 of their parameter; both saturate-free, reload-only.
// - clear low mid-message drops all latched and pending data; no done pulse.
// STRUCTURE
// - seg7_pkg: typedef enum {IDLE, SHOW1, SHOW2} sched_state_t.
// - seg7_pkg also holds: typedef logic [3:0] hex_digit_t; CH_BG/CH_MSG/CH_ALERT channel constants.
// - Sub-module seg7_hold_timer: loadable down-counter with a zero flag.
//   Instantiated twice: hold timer and blink timer.
// - Top level: state register, ch1/ch2 capture registers, pending1 flag, output mux register.
// TESTING (HOLD_CYCLES=8, BLINK_CYCLES=2)
// - Reset, then bg_digits=16'h1234, bg_en=4'hF: after 1 edge, digits 1,2,3,4; enables F; active_ch 0.
// - req1 with msg1=16'hC0C0, en1=4'hF: msg1 is shown 8 cycles; done1 pulses in the last cycle;
//   the display then returns to 16'h1234.
// - req2 with msg2=16'hEEEE, en2=4'hF: enables toggle F,F,0,0,F,F,0,0 over 8 cycles; done2 pulses once.
// - req1 and req2 on the same edge: ch2 is shown 8 cycles, then ch1 8 cycles; done2 fires, then done1.
// - req2 at cycle 3 of SHOW1: ch2 runs a full 8 cycles; ch1 then reruns a full 8 cycles.
//   Exactly one done1 is produced.
// - clear=0 in cycle 4 of SHOW2: next outputs are digits 0 and enables 0.
//   After release, IDLE shows bg; no done2 and no pending1.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display scheduler.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW1 = 2'd1,
    SHOW2 = 2'd2
  } sched_state_t;

  typedef logic [3:0] hex_digit_t;

  localparam logic [1:0] CH_BG    = 2'd0;
  localparam logic [1:0] CH_MSG   = 2'd1;
  localparam logic [1:0] CH_ALERT = 2'd2;

  // A one-cycle count still needs a 1-bit register.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_hold_timer.sv
// Loadable down-counter that stops at zero and flags it; load wins over count.
// Latency: zero flag reflects the registered count; no backpressure.
module seg7_hold_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seg7_display_scheduler.sv
// Time-shares a 4-digit display among background, timed message and blinking alert.
// Latency: one edge from state to registered outputs; requests are never stalled.
module seg7_display_scheduler
  import seg7_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [15:0] bg_digits,
  input  logic [3:0]  bg_en,
  input  logic        req1,
  input  logic [15:0] msg1,
  input  logic [3:0]  en1,
  input  logic        req2,
  input  logic [15:0] msg2,
  input  logic [3:0]  en2,
  output hex_digit_t  digit3,
  output hex_digit_t  digit2,
  output hex_digit_t  digit1,
  output hex_digit_t  digit0,
  output logic [3:0]  enables,
  output logic [1:0]  active_ch,
  output logic        done1,
  output logic        done2
);

  localparam int unsigned HW = cnt_width(HOLD_CYCLES);
  localparam int unsigned BW = cnt_width(BLINK_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_CYCLES - 1);

  sched_state_t state_q, state_d;
  logic [15:0]  msg1_q, msg1_d, msg2_q, msg2_d;
  logic [3:0]   en1_q, en1_d, en2_q, en2_d;
  logic         pending1_q, pending1_d;
  logic         blink_phase_q, blink_phase_d;
  logic [15:0]  digits_q, digits_d;
  logic [3:0]   enables_q, enables_d;
  logic [1:0]   active_ch_q, active_ch_d;
  logic         done1_q, done1_d, done2_q, done2_d;

  logic hold_load, hold_zero, blink_load, blink_zero, showing, blink_tick;

  seg7_hold_timer #(.WIDTH(HW)) u_hold_timer (
    .clk      (clk),
    .clear    (clear),
    .load     (hold_load),
    .load_val (HOLD_LOAD),
    .en       (showing),
    .zero     (hold_zero)
  );

  seg7_hold_timer #(.WIDTH(BW)) u_blink_timer (
    .clk      (clk),
    .clear    (clear),
    .load     (blink_load),
    .load_val (BLINK_LOAD),
    .en       (state_q == SHOW2),
    .zero     (blink_zero)
  );

  assign showing    = (state_q != IDLE);
  assign blink_tick = (state_q == SHOW2) && blink_zero;

  always_comb begin
    state_d       = state_q;
    msg1_d        = msg1_q;
    en1_d         = en1_q;
    msg2_d        = msg2_q;
    en2_d         = en2_q;
    pending1_d    = pending1_q;
    hold_load     = 1'b0;
    done1_d       = 1'b0;
    done2_d       = 1'b0;
    blink_load    = req2 || blink_tick;
    blink_phase_d = req2 ? 1'b1 : (blink_tick ? ~blink_phase_q : blink_phase_q);

    if (req2) begin
      msg2_d    = msg2;
      en2_d     = en2;
      state_d   = SHOW2;
      hold_load = 1'b1;
      if (state_q == SHOW1) begin
        pending1_d = 1'b1;
      end
      if (req1) begin
        msg1_d     = msg1;
        en1_d      = en1;
        pending1_d = 1'b1;
      end
    end else if (req1 && (state_q != SHOW2)) begin
      msg1_d    = msg1;
      en1_d     = en1;
      state_d   = SHOW1;
      hold_load = 1'b1;
    end else begin
      // Only reachable with req1 while the alert is up: queue it behind ch2.
      if (req1) begin
        msg1_d     = msg1;
        en1_d      = en1;
        pending1_d = 1'b1;
      end
      if (showing && hold_zero) begin
        if (state_q == SHOW1) begin
          done1_d = 1'b1;
          state_d = IDLE;
        end else begin
          done2_d = 1'b1;
          if (pending1_d) begin
            state_d    = SHOW1;
            hold_load  = 1'b1;
            pending1_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
    end
  end

  always_comb begin
    digits_d    = bg_digits;
    enables_d   = bg_en;
    active_ch_d = CH_BG;
    case (state_q)
      SHOW1: begin
        digits_d    = msg1_q;
        enables_d   = en1_q;
        active_ch_d = CH_MSG;
      end
      SHOW2: begin
        digits_d    = msg2_q;
        enables_d   = blink_phase_q ? en2_q : 4'h0;
        active_ch_d = CH_ALERT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q       <= IDLE;
      msg1_q        <= '0;
      en1_q         <= '0;
      msg2_q        <= '0;
      en2_q         <= '0;
      pending1_q    <= 1'b0;
      blink_phase_q <= 1'b1;
      digits_q      <= '0;
      enables_q     <= '0;
      active_ch_q   <= CH_BG;
      done1_q       <= 1'b0;
      done2_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      msg1_q        <= msg1_d;
      en1_q         <= en1_d;
      msg2_q        <= msg2_d;
      en2_q         <= en2_d;
      pending1_q    <= pending1_d;
      blink_phase_q <= blink_phase_d;
      digits_q      <= digits_d;
      enables_q     <= enables_d;
      active_ch_q   <= active_ch_d;
      done1_q       <= done1_d;
      done2_q       <= done2_d;
    end
  end

  assign digit3    = digits_q[15:12];
  assign digit2    = digits_q[11:8];
  assign digit1    = digits_q[7:4];
  assign digit0    = digits_q[3:0];
  assign enables   = enables_q;
  assign active_ch = active_ch_q;
  assign done1     = done1_q;
  assign done2     = done2_q;

endmodule
